// File: rtl/regfile_write_arbiter_if.sv
// Write-request, echo and register-file write-port bundle for regfile_write_arbiter.
// The arbiter takes the slave side; the requester/datapath environment takes the master side.
interface regfile_write_arbiter_if #(
  parameter int l = 16,
  parameter int a = 3
);
  localparam int r = 1 << a;

  logic         WbValid;
  logic         WbReady;
  logic [a-1:0] WbAddr;
  logic [l-1:0] WbData;

  logic         LdValid;
  logic         LdReady;
  logic [a-1:0] LdAddr;
  logic [l-1:0] LdData;

  logic         FlagValid;
  logic         FlagReady;
  logic [l-1:0] FlagData;

  logic [a-1:0] EchoAddr;
  logic [l-1:0] EchoData;

  logic [a-1:0] RfAddrA;
  logic [l-1:0] RfInDataA;
  logic [l-1:0] RfInNewFlags;
  logic         RfUpdateFlags;
  logic [r-1:0] PendingMask;
  logic         Busy;

  modport slave (
    input  WbValid, WbAddr, WbData,
    input  LdValid, LdAddr, LdData,
    input  FlagValid, FlagData,
    input  EchoAddr, EchoData,
    output WbReady, LdReady, FlagReady,
    output RfAddrA, RfInDataA, RfInNewFlags, RfUpdateFlags,
    output PendingMask, Busy
  );

  modport master (
    output WbValid, WbAddr, WbData,
    output LdValid, LdAddr, LdData,
    output FlagValid, FlagData,
    output EchoAddr, EchoData,
    input  WbReady, LdReady, FlagReady,
    input  RfAddrA, RfInDataA, RfInNewFlags, RfUpdateFlags,
    input  PendingMask, Busy
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter merging writeback and load writes into one register-file write port,
// with a separate flags-update path kept off the flags register whenever a data write targets it.
module regfile_write_arbiter #(
  parameter int l = 16,
  parameter int a = 3
) (
  input  logic                 Clk,
  input  logic                 Reset,
  regfile_write_arbiter_if.slave bus
);
  localparam int r = 1 << a;
  localparam logic [a-1:0] FA = {a{1'b1}};

  function automatic logic [r-1:0] onehot(input logic [a-1:0] idx);
    logic [r-1:0] m;
    m      = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

  logic         prio;
  logic         svalid_p0;
  logic [a-1:0] saddr_p0;
  logic [l-1:0] sdata_p0;
  logic         fvalid_p0;
  logic [l-1:0] fdata_p0;

  logic         grant_wb;
  logic         grant_ld;
  logic         grant_any;
  logic [a-1:0] grant_addr;
  logic [l-1:0] grant_data;
  logic         data_to_fa;
  logic         flag_take;

  always_comb begin
    grant_wb   = !Reset && bus.WbValid && (!bus.LdValid || !prio);
    grant_ld   = !Reset && bus.LdValid && (!bus.WbValid ||  prio);
    grant_any  = grant_wb || grant_ld;
    grant_addr = grant_wb ? bus.WbAddr : bus.LdAddr;
    grant_data = grant_wb ? bus.WbData : bus.LdData;
    // A flags update is held off when the same edge would also stage a data write to the flags register.
    data_to_fa = grant_any && (grant_addr == FA);
    flag_take  = !Reset && bus.FlagValid && !data_to_fa;
  end

  assign bus.WbReady   = grant_wb;
  assign bus.LdReady   = grant_ld;
  assign bus.FlagReady = flag_take;

  // Stage p0: accepted requests, committed to the register file on the following edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      prio      <= 1'b0;
      svalid_p0 <= 1'b0;
      saddr_p0  <= '0;
      sdata_p0  <= '0;
      fvalid_p0 <= 1'b0;
      fdata_p0  <= '0;
    end else begin
      svalid_p0 <= grant_any;
      fvalid_p0 <= flag_take;
      if (grant_any) begin
        saddr_p0 <= grant_addr;
        sdata_p0 <= grant_data;
        prio     <= grant_wb;
      end
      if (flag_take) begin
        fdata_p0 <= bus.FlagData;
      end
    end
  end

  // Commit: with nothing staged (or in reset) the port rewrites the echoed register with its own value.
  assign bus.RfAddrA       = (svalid_p0 && !Reset) ? saddr_p0 : bus.EchoAddr;
  assign bus.RfInDataA     = (svalid_p0 && !Reset) ? sdata_p0 : bus.EchoData;
  assign bus.RfUpdateFlags = fvalid_p0 && !Reset;
  assign bus.RfInNewFlags  = fdata_p0;
  assign bus.PendingMask   = (svalid_p0 && !Reset) ? onehot(saddr_p0) : '0;
  assign bus.Busy          = svalid_p0 || fvalid_p0;
endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter l, default 16, register data width in bits.
REQ-002 Parameter a, default 3, register address width; r = 2^a registers; flags register address FA = r-1.
REQ-003 Clk  in  1  single clock; all state updates on posedge Clk.
REQ-004 Reset  in  1  synchronous, active-high reset, sampled on posedge Clk.
REQ-005 WbValid in 1 / WbReady out 1 / WbAddr in a / WbData in l: execute-writeback write request channel.
REQ-006 LdValid in 1 / LdReady out 1 / LdAddr in a / LdData in l: load-unit write request channel.
REQ-007 FlagValid in 1 / FlagReady out 1 / FlagData in l: flags-update request channel.
REQ-008 EchoAddr in a / EchoData in l: datapath's current port-C address and the register file's matching port-C read data, used for idle rewrite.
REQ-009 RfAddrA out a / RfInDataA out l: register file write port, written on every clock edge.
REQ-010 RfInNewFlags out l / RfUpdateFlags out 1: register file flags write port.
REQ-011 PendingMask out r: bit k high when a staged write to register k commits at the next edge.
REQ-012 Busy out 1: high when any write is staged.

Function
REQ-013 Handshake: transfer occurs on a channel in a cycle where Valid and Ready are both high at posedge Clk; Ready shall be high only when the matching Valid is high.
REQ-014 Per cycle, at most one of WbReady/LdReady shall be high.
REQ-015 Round-robin: priority bit Prio (0=Wb, 1=Ld); with both Valid, priority requester granted; with one Valid, that one granted.
REQ-016 After any Wb or Ld grant, Prio shall point to the requester not granted.
REQ-017 Data stage registers SValid/SAddr/SData load the granted request at the edge; SValid=0 if no grant.
REQ-018 Flag stage registers FValid/FData load FlagData when FlagValid and FlagReady; FValid=0 otherwise.
REQ-019 FlagReady = FlagValid, except low in a cycle where a granted data write targets FA.
REQ-020 Latency: request accepted at edge N commits to the register file at edge N+1; one data write and one flags update per cycle max throughput.
REQ-021 RfAddrA/RfInDataA = SAddr/SData when SValid, else EchoAddr/EchoData (harmless rewrite of unchanged value).
REQ-022 RfUpdateFlags = FValid; RfInNewFlags = FData.
REQ-023 Data write to FA and flags update shall never commit at the same edge (guaranteed by REQ-019).
REQ-024 PendingMask = one-hot(SAddr) when SValid, else zero; Busy = SValid or FValid.
REQ-025 Wb and Ld to the same address both Valid: only one granted; other waits, granted next cycle (Prio flipped).

Reset
REQ-026 While Reset is high: all Ready outputs 0; RfAddrA/RfInDataA forced to EchoAddr/EchoData and RfUpdateFlags forced to 0 combinationally, discarding any staged write.
REQ-027 On the edge with Reset high: SValid=0, FValid=0, SAddr=0, SData=0, FData=0, Prio=0; hence PendingMask=0, Busy=0, RfInNewFlags=0.
REQ-028 Reset mid-operation: requests accepted at the edge before Reset rises never commit; requesters must re-present.

Verification
REQ-029 Idle: no Valid, EchoAddr=3, EchoData=0x1234 -> RfAddrA=3, RfInDataA=0x1234, RfUpdateFlags=0, Busy=0.
REQ-030 Single Wb: WbAddr=2, WbData=0xBEEF for one cycle -> WbReady=1; next cycle RfAddrA=2, RfInDataA=0xBEEF, PendingMask=0x04; register 2 reads 0xBEEF after that edge.
REQ-031 Contention: Wb(1,0x1111) and Ld(5,0x5555) held Valid after reset -> Wb granted first, Ld next cycle; sustained both-Valid alternates Wb, Ld, Wb, Ld.
REQ-032 Flag conflict: Wb write to address 7 (a=3) and FlagValid same cycle -> WbReady=1, FlagReady=0; flags committed one cycle later; register 7 ends with FlagData.
REQ-033 Reset mid-flight: Ld(4,0xAAAA) accepted, Reset high next cycle -> RfAddrA=EchoAddr, RfUpdateFlags=0, register 4 unchanged, PendingMask=0 after reset.
REQ-034 Throughput: Wb Valid continuously with FlagValid continuously to non-FA addresses -> one data write and one flags update commit every cycle, Busy=1 throughout.
